// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 active-low matrix keypad.
// Watches the scanner's column strobes and pulls the matching row low while a
// commanded key is held. Press and release lengths are counted in scanner strobes,
// so the emulator follows whatever scan rate the reader uses.
//
// Optional build macro: KEYPAD_EMU_BOUNCE_EN
//   Defined   - the contact chatters (LFSR driven) for BOUNCE_CYCLES clocks after
//               entering HOLD and after entering RELEASE; strobe counting waits for
//               the chatter window to end.
//   Undefined - the contact follows the state cleanly; no LFSR or bounce timer exists.

module keypad_emulator #(
    parameter int unsigned HOLD_SCANS    = 4,
    parameter int unsigned RELEASE_SCANS = 2,
    parameter int unsigned BOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic       ready,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int unsigned MaxScans = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
    localparam int unsigned CntW     = (MaxScans > 0) ? $clog2(MaxScans + 1) : 1;

    localparam logic [CntW-1:0] HoldTerm = CntW'(HOLD_SCANS);
    localparam logic [CntW-1:0] RelTerm  = CntW'(RELEASE_SCANS);

    // Zero-length press/release or an absurd bounce length has no meaningful
    // terminal count; such a configuration elaborates this empty marker block.
    if (HOLD_SCANS < 1 || RELEASE_SCANS < 1 || BOUNCE_CYCLES > 65535) begin : g_bad_params
    end

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRelease,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      row_sel_q, row_sel_d;
    logic [1:0]      col_sel_q, col_sel_d;
    logic [3:0]      col_prev_q, col_prev_d;

    logic [1:0]      dec_row;
    logic [1:0]      dec_col;
    logic            hold_edge;
    logic            rel_edge;
    logic            contact;
    logic            count_en;

    // Key code to (row, column) position on the pad.
    always_comb begin
        dec_row = 2'd0;
        dec_col = 2'd0;
        unique case (key_code)
            4'h1: begin dec_row = 2'd0; dec_col = 2'd0; end
            4'h2: begin dec_row = 2'd0; dec_col = 2'd1; end
            4'h3: begin dec_row = 2'd0; dec_col = 2'd2; end
            4'hA: begin dec_row = 2'd0; dec_col = 2'd3; end
            4'h4: begin dec_row = 2'd1; dec_col = 2'd0; end
            4'h5: begin dec_row = 2'd1; dec_col = 2'd1; end
            4'h6: begin dec_row = 2'd1; dec_col = 2'd2; end
            4'hB: begin dec_row = 2'd1; dec_col = 2'd3; end
            4'h7: begin dec_row = 2'd2; dec_col = 2'd0; end
            4'h8: begin dec_row = 2'd2; dec_col = 2'd1; end
            4'h9: begin dec_row = 2'd2; dec_col = 2'd2; end
            4'hC: begin dec_row = 2'd2; dec_col = 2'd3; end
            4'hE: begin dec_row = 2'd3; dec_col = 2'd0; end
            4'h0: begin dec_row = 2'd3; dec_col = 2'd1; end
            4'hF: begin dec_row = 2'd3; dec_col = 2'd2; end
            4'hD: begin dec_row = 2'd3; dec_col = 2'd3; end
            default: begin dec_row = 2'd0; dec_col = 2'd0; end
        endcase
    end

    // Strobe falling edges: the held key's column during HOLD, col[0] during RELEASE.
    always_comb begin
        col_prev_d = col;
        hold_edge  = col_prev_q[col_sel_q] & ~col[col_sel_q];
        rel_edge   = col_prev_q[0] & ~col[0];
    end

    // Press/hold/release sequencing; counter saturates at its terminal value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_sel_d = row_sel_q;
        col_sel_d = col_sel_q;
        unique case (state_q)
            StIdle: begin
                if (press_req) begin
                    row_sel_d = dec_row;
                    col_sel_d = dec_col;
                    cnt_d     = '0;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (cnt_q == HoldTerm) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (hold_edge && count_en) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                if (cnt_q == RelTerm) begin
                    state_d = StDone;
                end else if (rel_edge && count_en) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, counter, latched key position and column history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            row_sel_q  <= 2'd0;
            col_sel_q  <= 2'd0;
            col_prev_q <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_sel_q  <= row_sel_d;
            col_sel_q  <= col_sel_d;
            col_prev_q <= col_prev_d;
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int unsigned BncW = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;

    logic [7:0]      lfsr_q, lfsr_d;
    logic [BncW-1:0] bnc_q, bnc_d;
    logic            entering;

    // Free-running x^8+x^6+x^5+x^4+1 LFSR and the chatter-window timer.
    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        entering = (state_d != state_q) && ((state_d == StHold) || (state_d == StRelease));
        if (entering) begin
            bnc_d = BncW'(BOUNCE_CYCLES);
        end else if (bnc_q != '0) begin
            bnc_d = bnc_q - BncW'(1);
        end else begin
            bnc_d = bnc_q;
        end
    end

    // LFSR and bounce timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
            bnc_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            bnc_q  <= bnc_d;
        end
    end

    // Contact chatters inside the window; strobes are ignored until it settles.
    always_comb begin
        contact  = (bnc_q != '0) ? lfsr_q[0] : (state_q == StHold);
        count_en = (bnc_q == '0);
    end
`else
    // Contact follows the state register directly.
    always_comb begin
        contact  = (state_q == StHold);
        count_en = 1'b1;
    end
`endif

    // Passive switch: row pulled low only while the key's column is strobed.
    always_comb begin
        row = 4'hF;
        if (contact && !col[col_sel_q]) begin
            row[row_sel_q] = 1'b0;
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q == StHold) || (state_q == StRelease);
        done  = (state_q == StDone);
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus pushes accepted key codes, a
// monitor checks row patterns against a hand-written key map and, on each done
// pulse, the number of closed strobes and release strobes of that press.

module tb_keypad_emulator;

    localparam int unsigned HoldScans = 4;
    localparam int unsigned RelScans  = 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [3:0] col       = 4'hF;
    logic [3:0] row;
    logic [3:0] key_code  = 4'h0;
    logic       press_req = 1'b0;
    logic       ready;
    logic       busy;
    logic       done;

    logic       scan_en   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int pushes      = 0;
    int flushed     = 0;
    int accepts     = 0;
    int done_cnt    = 0;

    logic [3:0] sb[$];

    keypad_emulator #(
        .HOLD_SCANS   (HoldScans),
        .RELEASE_SCANS(RelScans),
        .BOUNCE_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .press_req(press_req),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-written pad layout: code -> (row, column).
    function automatic void key_pos(input logic [3:0] code, output int r, output int c);
        case (code)
            4'h1: begin r = 0; c = 0; end
            4'h2: begin r = 0; c = 1; end
            4'h3: begin r = 0; c = 2; end
            4'hA: begin r = 0; c = 3; end
            4'h4: begin r = 1; c = 0; end
            4'h5: begin r = 1; c = 1; end
            4'h6: begin r = 1; c = 2; end
            4'hB: begin r = 1; c = 3; end
            4'h7: begin r = 2; c = 0; end
            4'h8: begin r = 2; c = 1; end
            4'h9: begin r = 2; c = 2; end
            4'hC: begin r = 2; c = 3; end
            4'hE: begin r = 3; c = 0; end
            4'h0: begin r = 3; c = 1; end
            4'hF: begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end
        endcase
    endfunction

    // Scanner: each column strobed low for 4 clocks, col[0] first.
    initial begin
        int phase;
        logic [3:0] one;
        phase = 0;
        one   = 4'b0001;
        forever begin
            @(posedge clk);
            #2;
            if (!scan_en) begin
                col   = 4'hF;
                phase = 0;
            end else begin
                col   = ~(one << (phase / 4));
                phase = (phase + 1) % 16;
            end
        end
    end

    // Monitor: row checks every cycle, per-press totals on done.
    initial begin
        logic [3:0] prev_col;
        logic [3:0] exp_row;
        bit counted, eligible, after_done;
        int closed, rel, r, c;
        prev_col = 4'hF;
        counted = 0; eligible = 0; after_done = 0;
        closed = 0; rel = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                closed = 0; rel = 0; counted = 0; eligible = 0; after_done = 0;
                prev_col = col;
            end else begin
                if (after_done) begin
                    chk("post_done_done", int'(done), 0);
                    chk("post_done_busy", int'(busy), 0);
                    chk("post_done_ready", int'(ready), 1);
                    after_done = 0;
                end
                if (press_req && ready) accepts++;
                // A strobe only counts if it began while the key was commanded.
                if (col != prev_col) begin
                    counted  = 0;
                    eligible = busy;
                end
                if (prev_col[0] && !col[0]) rel++;
                if (row != 4'hF) begin
                    if (sb.size() == 0) begin
                        chk("row_unexpected", int'(row), 'hF);
                    end else begin
                        key_pos(sb[0], r, c);
                        exp_row    = 4'hF;
                        exp_row[r] = 1'b0;
                        if (col[c] == 1'b0) chk("row_pattern", int'(row), int'(exp_row));
                        else chk("row_without_strobe", int'(row), 'hF);
                        if (eligible && !counted) closed++;
                        counted = 1;
                        rel     = 0;
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        chk("done_unexpected", int'(done), 0);
                    end else begin
                        chk("hold_strobes", closed, HoldScans);
                        chk("release_strobes", rel, RelScans);
                        void'(sb.pop_front());
                    end
                    closed = 0; rel = 0; after_done = 1;
                end
                prev_col = col;
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", int'(ready), 1);
    endtask

    task automatic press(input logic [3:0] code);
        bit ok;
        @(posedge clk);
        #1;
        key_code  = code;
        press_req = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        if (ok) begin
            sb.push_back(code);
            pushes++;
        end
        #1;
        press_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        bit ok;
        int saved_done;
        bit found;

        // Reset values.
        #1;
        chk("reset_row", int'(row), 'hF);
        chk("reset_ready", int'(ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        scan_en = 1'b1;

        // '5', then the corner keys '*' and 'D'.
        press(4'h5);
        drain();
        press(4'hE);
        drain();
        press(4'hD);
        drain();

        // Scanner stopped after acceptance: nothing may happen.
        @(posedge clk);
        #1;
        scan_en = 1'b0;
        press(4'h3);
        saved_done = done_cnt;
        repeat (40) @(negedge clk);
        chk("stopped_row", int'(row), 'hF);
        chk("stopped_busy", int'(busy), 1);
        chk("stopped_no_done", done_cnt, saved_done);
        @(posedge clk);
        #1;
        scan_en = 1'b1;
        drain();

        // Reset in the middle of holding '9'.
        press(4'h9);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (row == 4'b1011) begin
                found = 1;
                break;
            end
        end
        chk("hold_row_seen", int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_row", int'(row), 'hF);
        chk("midreset_ready", int'(ready), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        flushed += sb.size();
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        press(4'h5);
        drain();

        // press_req held high: 0x1 is served, then 0x9 right after done.
        @(posedge clk);
        #1;
        key_code  = 4'h1;
        press_req = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        if (ok) begin
            sb.push_back(4'h1);
            pushes++;
        end
        #1;
        key_code = 4'h9;
        wait_ready(ok);
        @(posedge clk);
        if (ok) begin
            sb.push_back(4'h9);
            pushes++;
        end
        #1;
        press_req = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        chk("accept_count", accepts, pushes);
        chk("done_count", done_cnt, pushes - flushed);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
